// File: rtl/fus_trace_buffer.sv
// fus_trace_buffer: watches the scoreboard FU status bus, turns ISSUE / READ /
// RELEASE transitions into records and queues them in a FWFT FIFO for a debug host.
// Optional build macro: FUS_TRACE_TIMESTAMP_EN adds a free-running timestamp field.
module fus_trace_buffer #(
    parameter int unsigned FU_NUM  = 6,
    parameter int unsigned Q_WIDTH = 3,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TS_W    = 16,
    localparam int unsigned FUS_W    = 23 + 2 * Q_WIDTH,
    localparam int unsigned FU_IDX_W = $clog2(FU_NUM),
`ifdef FUS_TRACE_TIMESTAMP_EN
    localparam int unsigned REC_W    = TS_W + FU_IDX_W + 7,
`else
    localparam int unsigned REC_W    = FU_IDX_W + 7,
`endif
    localparam int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [FU_NUM*FUS_W-1:0] fus_status,
    input  logic                    rd_en,
    output logic                    rd_valid,
    output logic [REC_W-1:0]        rd_data,
    output logic [CNT_W-1:0]        count,
    output logic [15:0]             drop_cnt
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned NCODE = 3;                        // 0:ISSUE 1:READ 2:RELEASE
    localparam int unsigned PL_W  = REC_W - FU_IDX_W - 2;     // pending payload {ts, fi}
    localparam int unsigned DRP_W = $clog2(NCODE * FU_NUM + 2);
    localparam int unsigned RJ_B  = 21 + 2 * Q_WIDTH;
    localparam int unsigned RK_B  = 22 + 2 * Q_WIDTH;
`ifndef FUS_TRACE_TIMESTAMP_EN
    localparam int unsigned UNUSED_TS_W = TS_W;
`endif

    logic [FU_NUM*FUS_W-1:0]                snap_q, snap_d;
    logic                                   prime_q, prime_d;
    logic [FU_NUM-1:1][NCODE-1:0]           pend_q, pend_d;
    logic [FU_NUM-1:1][NCODE-1:0][PL_W-1:0] pl_q, pl_d;
    logic [DEPTH-1:0][REC_W-1:0]            mem_q, mem_d;
    logic [PTR_W-1:0]                       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                       cnt_q, cnt_d;
    logic [15:0]                            drop_q, drop_d;
`ifdef FUS_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]                        ts_q, ts_d;
`endif

    logic [FU_NUM-1:1][NCODE-1:0] ev;
    logic [FU_NUM-1:1][4:0]       fi_old, fi_new;
    logic                         pop, push, gnt;
    logic [REC_W-1:0]             gnt_rec;
    logic [DRP_W-1:0]             n_drop;
    logic [16:0]                  drop_sum;
    logic                         unused_snap;

    // Event detection: compare each slot's new status with last cycle's snapshot
    always_comb begin
        ev     = '0;
        fi_old = '0;
        fi_new = '0;
        for (int unsigned k = 1; k < FU_NUM; k++) begin
            fi_old[k] = snap_q[k*FUS_W+6 +: 5];
            fi_new[k] = fus_status[k*FUS_W+6 +: 5];
            if (en && prime_q) begin
                ev[k][0] = fus_status[k*FUS_W] && (!snap_q[k*FUS_W] || (fi_new[k] != fi_old[k]));
                ev[k][1] = snap_q[k*FUS_W] && fus_status[k*FUS_W] && (fi_new[k] == fi_old[k])
                           && snap_q[k*FUS_W+RJ_B] && snap_q[k*FUS_W+RK_B]
                           && !(fus_status[k*FUS_W+RJ_B] && fus_status[k*FUS_W+RK_B]);
                ev[k][2] = snap_q[k*FUS_W] && !fus_status[k*FUS_W];
            end
        end
    end

    // Next state: arbitration, pending capture, FIFO and drop accounting
    always_comb begin
        snap_d   = snap_q;
        prime_d  = prime_q;
        pend_d   = pend_q;
        pl_d     = pl_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        gnt      = 1'b0;
        gnt_rec  = '0;
        n_drop   = '0;
        pop      = rd_en && (cnt_q != '0);
`ifdef FUS_TRACE_TIMESTAMP_EN
        ts_d     = ts_q + TS_W'(1);
`endif
        if (en) begin
            snap_d  = fus_status;
            prime_d = 1'b1;
        end
        // lowest slot first, ISSUE > READ > RELEASE within a slot
        for (int unsigned k = 1; k < FU_NUM; k++) begin
            for (int unsigned c = 0; c < NCODE; c++) begin
                if (!gnt && pend_q[k][c]) begin
                    gnt          = 1'b1;
                    pend_d[k][c] = 1'b0;
`ifdef FUS_TRACE_TIMESTAMP_EN
                    gnt_rec = {pl_q[k][c][PL_W-1:5], FU_IDX_W'(k), 2'(c + 1), pl_q[k][c][4:0]};
`else
                    gnt_rec = {FU_IDX_W'(k), 2'(c + 1), pl_q[k][c]};
`endif
                end
            end
        end
        push = gnt && ((cnt_q != CNT_W'(DEPTH)) || pop);
        if (gnt && !push) begin
            n_drop = n_drop + DRP_W'(1);
        end
        // a bit freed by this cycle's grant may be refilled without counting a drop
        for (int unsigned k = 1; k < FU_NUM; k++) begin
            for (int unsigned c = 0; c < NCODE; c++) begin
                if (ev[k][c]) begin
                    if (pend_d[k][c]) begin
                        n_drop = n_drop + DRP_W'(1);
                    end
                    pend_d[k][c]        = 1'b1;
                    pl_d[k][c][4:0]     = (c == 2) ? fi_old[k] : fi_new[k];
`ifdef FUS_TRACE_TIMESTAMP_EN
                    pl_d[k][c][PL_W-1:5] = ts_q;
`endif
                end
            end
        end
        if (push) begin
            mem_d[wr_ptr_q] = gnt_rec;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        drop_sum = 17'(drop_q) + 17'(n_drop);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q   <= '0;
            prime_q  <= 1'b0;
            pend_q   <= '0;
            pl_q     <= '0;
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            drop_q   <= '0;
`ifdef FUS_TRACE_TIMESTAMP_EN
            ts_q     <= '0;
`endif
        end else begin
            snap_q   <= snap_d;
            prime_q  <= prime_d;
            pend_q   <= pend_d;
            pl_q     <= pl_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
`ifdef FUS_TRACE_TIMESTAMP_EN
            ts_q     <= ts_d;
`endif
        end
    end

    // FWFT read side and status outputs
    assign rd_valid    = (cnt_q != '0);
    assign rd_data     = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign count       = cnt_q;
    assign drop_cnt    = drop_q;
    assign unused_snap = ^snap_q;

endmodule

// File: tb/tb_fus_trace_buffer.sv
// Bench for fus_trace_buffer: directed scenarios plus random status traffic,
// checked against a queue-based reference model and a record scoreboard.
module tb_fus_trace_buffer;
    localparam int FU_NUM  = 6;
    localparam int Q_WIDTH = 3;
    localparam int DEPTH   = 8;
    localparam int FUS_W   = 23 + 2 * Q_WIDTH;
`ifdef FUS_TRACE_TIMESTAMP_EN
    localparam int REC_W   = 16 + 10;
`else
    localparam int REC_W   = 10;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    en = 1'b0;
    logic                    rd_en = 1'b0;
    logic [FU_NUM*FUS_W-1:0] fus_status = '0;
    logic                    rd_valid;
    logic [REC_W-1:0]        rd_data;
    logic [3:0]              count;
    logic [15:0]             drop_cnt;

    int total = 0;
    int bad   = 0;

    // stimulus-side view of each slot
    bit          s_busy[FU_NUM];
    logic [4:0]  s_fi[FU_NUM];
    bit          s_rj[FU_NUM];
    bit          s_rk[FU_NUM];
    logic [31:0] s_misc[FU_NUM];

    // reference model state
    bit          m_busy[FU_NUM];
    logic [4:0]  m_fi[FU_NUM];
    bit          m_rr[FU_NUM];
    bit          m_prime;
    int          m_ts;
    bit          m_pend[FU_NUM][3];
    logic [4:0]  m_pfi[FU_NUM][3];
    int          m_pts[FU_NUM][3];
    int          m_cnt;
    int          m_drop;
    logic [REC_W-1:0] exp_q[$];

    fus_trace_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fus_status (fus_status),
        .rd_en      (rd_en),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .count      (count),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        logic [FUS_W-1:0] sl;
        for (int k = 0; k < FU_NUM; k++) begin
            sl                 = s_misc[k][FUS_W-1:0];
            sl[0]              = s_busy[k];
            sl[10:6]           = s_fi[k];
            sl[21 + 2*Q_WIDTH] = s_rj[k];
            sl[22 + 2*Q_WIDTH] = s_rk[k];
            fus_status[k*FUS_W +: FUS_W] = sl;
        end
    endtask

    function automatic logic [REC_W-1:0] mk_rec(int k, int c, logic [4:0] fi, int ts);
        logic [9:0] base;
        base = {3'(k), 2'(c + 1), fi};
`ifdef FUS_TRACE_TIMESTAMP_EN
        return {16'(ts), base};
`else
        return base;
`endif
    endfunction

    task automatic m_reset();
        for (int k = 0; k < FU_NUM; k++) begin
            m_busy[k] = 0; m_fi[k] = '0; m_rr[k] = 0;
            for (int c = 0; c < 3; c++) begin
                m_pend[k][c] = 0; m_pfi[k][c] = '0; m_pts[k][c] = 0;
            end
        end
        m_prime = 0; m_ts = 0; m_cnt = 0; m_drop = 0;
        exp_q.delete();
    endtask

    // one clock of the reference model, using the inputs the DUT will sample next edge
    task automatic model_step();
        int gk, gc, nd;
        bit pop, nb, ob, nrr;
        bit ev[3];
        if (rst) begin
            m_reset();
            return;
        end
        pop = rd_en && (m_cnt > 0);
        nd  = 0;
        gk  = -1;
        gc  = 0;
        for (int k = 1; k < FU_NUM; k++)
            for (int c = 0; c < 3; c++)
                if (gk < 0 && m_pend[k][c]) begin gk = k; gc = c; end
        if (gk >= 0) begin
            m_pend[gk][gc] = 0;
            if (m_cnt < DEPTH || pop) begin
                exp_q.push_back(mk_rec(gk, gc, m_pfi[gk][gc], m_pts[gk][gc]));
                m_cnt++;
            end else begin
                nd++;
            end
        end
        if (pop) m_cnt--;
        if (en && m_prime) begin
            for (int k = 1; k < FU_NUM; k++) begin
                nb    = s_busy[k];
                ob    = m_busy[k];
                nrr   = s_rj[k] && s_rk[k];
                ev[0] = nb && (!ob || s_fi[k] != m_fi[k]);
                ev[1] = ob && nb && (s_fi[k] == m_fi[k]) && m_rr[k] && !nrr;
                ev[2] = ob && !nb;
                for (int c = 0; c < 3; c++) begin
                    if (ev[c]) begin
                        if (m_pend[k][c]) nd++;
                        m_pend[k][c] = 1;
                        m_pfi[k][c]  = (c == 2) ? m_fi[k] : s_fi[k];
                        m_pts[k][c]  = m_ts;
                    end
                end
            end
        end
        if (en) begin
            for (int k = 0; k < FU_NUM; k++) begin
                m_busy[k] = s_busy[k]; m_fi[k] = s_fi[k]; m_rr[k] = s_rj[k] && s_rk[k];
            end
            m_prime = 1;
        end
        m_ts   = (m_ts + 1) % 65536;
        m_drop = (m_drop + nd > 65535) ? 65535 : m_drop + nd;
    endtask

    // reference model: compare occupancy/drops every cycle, then advance
    initial begin
        m_reset();
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("count", count, m_cnt);
            chk("drop_cnt", drop_cnt, m_drop);
            chk("rd_valid", rd_valid, m_cnt != 0);
            model_step();
        end
    end

    // scoreboard monitor: every accepted pop must match the oldest expected record
    initial begin
        logic [REC_W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && rd_en && rd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", rd_data, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] e10;
        int fus3[3];
        fus3 = '{1, 3, 4};
        for (int k = 0; k < FU_NUM; k++) begin
            s_busy[k] = 0; s_fi[k] = '0; s_rj[k] = 0; s_rk[k] = 0; s_misc[k] = $urandom;
        end
        s_busy[0] = 1; s_fi[0] = 5'd9;
        drive();
        rst = 1; en = 1; rd_en = 0;
        repeat (3) tick();
        rst = 0;                                   // cycle 0
        @(negedge clk);
        chk("rst_valid", rd_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_data", rd_data, 0);

        // slot 2 issues at cycle 10; slot 0 activity must be ignored
        repeat (10) tick();
        s_busy[2] = 1; s_fi[2] = 5'd5; s_busy[0] = 0;
        drive();
        tick(); tick();                            // cycle 12
        @(negedge clk);
        chk("lat_valid", rd_valid, 1);
        e10 = {3'd2, 2'b01, 5'd5};
        chk("lat_rec", rd_data[9:0], e10);
`ifdef FUS_TRACE_TIMESTAMP_EN
        chk("lat_ts", rd_data[REC_W-1:10], 10);
`endif
        tick(); rd_en = 1; tick(); rd_en = 0;

        // three simultaneous issues drain in slot order
        s_busy[1] = 1; s_fi[1] = 5'd1; s_busy[3] = 1; s_fi[3] = 5'd3; s_busy[4] = 1; s_fi[4] = 5'd4;
        drive();
        repeat (6) tick();
        @(negedge clk);
        chk("multi_count", count, 3);
        chk("multi_drop", drop_cnt, 0);
        tick(); rd_en = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("multi_order", rd_data[9:7], fus3[i]);
            tick();
        end
        rd_en = 0;
        @(negedge clk);
        chk("multi_empty", count, 0);

        // read-ready drop together with release: only a RELEASE with the old fi
        tick();
        s_rj[1] = 1; s_rk[1] = 1; drive();
        tick();
        s_rj[1] = 0; s_busy[1] = 0; s_fi[1] = 5'd30; drive();
        repeat (5) tick();
        @(negedge clk);
        chk("rel_count", count, 1);
        e10 = {3'd1, 2'b11, 5'd1};
        chk("rel_rec", rd_data[9:0], e10);
        tick(); rd_en = 1; tick(); rd_en = 0;

        // ten events with no reads: FIFO fills and two are dropped
        s_busy[2] = 0; s_busy[3] = 0; s_busy[4] = 0; drive();
        rd_en = 1; repeat (12) tick(); rd_en = 0;
        @(negedge clk);
        chk("pre_fill_empty", count, 0);
        tick();
        for (int k = 1; k < FU_NUM; k++) begin s_busy[k] = 1; s_fi[k] = 5'(k + 10); end
        drive(); tick();
        for (int k = 1; k < FU_NUM; k++) s_busy[k] = 0;
        drive();
        repeat (14) tick();
        @(negedge clk);
        chk("fill_count", count, 8);
        chk("fill_drop", drop_cnt, 2);

        // full FIFO, pop and push in the same cycle
        tick();
        s_busy[1] = 1; s_fi[1] = 5'd7; drive();
        tick(); rd_en = 1;
        tick(); rd_en = 0;
        @(negedge clk);
        chk("fullpop_count", count, 8);
        chk("fullpop_drop", drop_cnt, 2);
        tick(); rd_en = 1; repeat (8) tick(); rd_en = 0;
        @(negedge clk);
        chk("drain_valid", rd_valid, 0);

        // reset with records stored and events pending
        tick();
        for (int k = 2; k < FU_NUM; k++) begin s_busy[k] = 1; s_fi[k] = 5'($urandom); end
        s_fi[1] = 5'd20; drive();
        repeat (8) tick();
        @(negedge clk);
        chk("prerst_count", count, 5);
        tick();
        s_fi[1] = 5'd21; s_fi[2] = s_fi[2] ^ 5'd1; drive();
        tick(); rst = 1;
        tick(); rst = 0;
        @(negedge clk);
        chk("midrst_count", count, 0);
        chk("midrst_valid", rd_valid, 0);
        chk("midrst_drop", drop_cnt, 0);
        repeat (3) tick();
        @(negedge clk);
        chk("prime_norec", count, 0);
        tick();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            en    = ($urandom_range(0, 15) != 0);
            rd_en = ((i % 400) < 60) ? 1'b0 : ($urandom_range(0, 3) != 0);
            for (int k = 0; k < FU_NUM; k++) begin
                s_misc[k] = $urandom;
                if (en && $urandom_range(0, 7) == 0) begin
                    case ($urandom_range(0, 3))
                        0: begin s_busy[k] = !s_busy[k]; s_fi[k] = 5'($urandom); end
                        1: s_fi[k] = 5'($urandom);
                        2: begin s_rj[k] = 1; s_rk[k] = 1; end
                        default: begin s_rj[k] = 1'($urandom); s_rk[k] = 1'($urandom); end
                    endcase
                end
            end
            drive();
            tick();
        end

        // final drain with quiet status
        en = 1; rd_en = 1;
        repeat (40) tick();
        @(negedge clk);
        chk("final_empty", rd_valid, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
